layer_sequencer: RTL and testbench

- Top-level scheduler for the shared convolution/affine datapath.
- On start, steps the layer code through 0..NUM_LAYERS-1. For each layer it issues one load pulse to the datapath, waits for the datapath's valid, and then pulses a capture strobe so the activation buffer stores the result.
- A ping-pong select picks which activation buffer bank is read and which is written.
- Sits between the host/testbench start handshake and the cnn_layer datapath plus its activation buffers.

---
 rtl/layer_sequencer_if.sv | 24 ++
 rtl/layer_sequencer.sv | 137 +++++++++++++
 tb/tb_layer_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// Handshake bundle between the host/datapath side (master) and the layer sequencer (slave).
// Carries start, the datapath valid, and all sequencing outputs.
interface layer_sequencer_if;
    logic       start;
    logic       layer_valid;
    logic       layer_load;
    logic [3:0] cs_layer;
    logic       is_affine;
    logic       buf_sel;
    logic       capture;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, layer_valid,
        input  layer_load, cs_layer, is_affine, buf_sel, capture, busy, done, err
    );

    modport slave (
        input  start, layer_valid,
        output layer_load, cs_layer, is_affine, buf_sel, capture, busy, done, err
    );
endinterface

// File: rtl/layer_sequencer.sv
// Layer scheduler for the shared conv/affine datapath: load, wait for valid, capture, advance.
// Optional WAIT watchdog with sticky error state enabled by `define LAYER_SEQ_WATCHDOG_EN.
module layer_sequencer #(
    parameter int NUM_LAYERS  = 4,
    parameter int MIN_WAIT    = 2
`ifdef LAYER_SEQ_WATCHDOG_EN
    , parameter int WDOG_CYCLES = 65535
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    layer_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CAPT,
        S_NEXT,
        S_FINI
`ifdef LAYER_SEQ_WATCHDOG_EN
        , S_ERR
`endif
    } state_t;

    localparam logic [3:0] LAST_LAYER = 4'(NUM_LAYERS - 1);
    localparam int         WCW        = $clog2(MIN_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX  = '1;
    // wait_cnt counts WAIT cycles already spent, so the current WAIT cycle is
    // wait_cnt+1 cycles after load; valid counts once that reaches MIN_WAIT.
    localparam logic [WCW-1:0] WAIT_GATE = WCW'(MIN_WAIT - 1);

    state_t         state;
    state_t         state_next;
    logic [3:0]     cs_layer;
    logic           buf_sel;
    logic [WCW-1:0] wait_cnt;
    logic           valid_ok;
    logic           run_start;

    assign valid_ok = (state == S_WAIT) && (wait_cnt >= WAIT_GATE) && bus.layer_valid;

`ifdef LAYER_SEQ_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_cnt;
    logic        wdog_hit;

    assign wdog_hit  = (state == S_WAIT) && !valid_ok && (wdog_cnt >= WDOG_LAST);
    assign run_start = bus.start && ((state == S_IDLE) || (state == S_ERR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (state == S_LOAD) begin
            wdog_cnt <= '0;
        end else if ((state == S_WAIT) && (wdog_cnt != 16'hFFFF)) begin
            wdog_cnt <= wdog_cnt + 16'd1;
        end
    end
`else
    assign run_start = bus.start && (state == S_IDLE);
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (run_start) state_next = S_LOAD;
            S_LOAD: state_next = S_WAIT;
            S_WAIT: begin
                if (valid_ok) begin
                    state_next = S_CAPT;
                end
`ifdef LAYER_SEQ_WATCHDOG_EN
                else if (wdog_hit) begin
                    state_next = S_ERR;
                end
`endif
            end
            S_CAPT: state_next = (cs_layer == LAST_LAYER) ? S_FINI : S_NEXT;
            S_NEXT: state_next = S_LOAD;
            S_FINI: state_next = S_IDLE;
`ifdef LAYER_SEQ_WATCHDOG_EN
            S_ERR:  if (run_start) state_next = S_LOAD;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_layer <= '0;
            buf_sel  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (run_start) begin
                cs_layer <= '0;
                buf_sel  <= 1'b0;
            end
            if (state == S_LOAD) begin
                wait_cnt <= '0;
            end else if ((state == S_WAIT) && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // NEXT is only reachable below the last layer, so no wrap check is needed.
            if (state == S_NEXT) begin
                cs_layer <= cs_layer + 4'd1;
                buf_sel  <= ~buf_sel;
            end
        end
    end

    assign bus.layer_load = (state == S_LOAD);
    assign bus.capture    = (state == S_CAPT);
    assign bus.done       = (state == S_FINI);
    assign bus.busy       = (state != S_IDLE);
    assign bus.cs_layer   = cs_layer;
    assign bus.is_affine  = (cs_layer == LAST_LAYER);
    assign bus.buf_sel    = buf_sel;
`ifdef LAYER_SEQ_WATCHDOG_EN
    assign bus.err        = (state == S_ERR);
`else
    assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a 4-layer and a 1-layer instance, randomized datapath latency.
// Watchdog scenario is included when LAYER_SEQ_WATCHDOG_EN is defined.
module tb_layer_sequencer;
    localparam int MIN_WAIT = 2;
    localparam int MAX_LAT  = 12;
`ifdef LAYER_SEQ_WATCHDOG_EN
    localparam int WDOG = 20;
`endif

    typedef struct {
        int layer;
        int bank;
        int affine;
        int cyc;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_sequencer_if bus0 ();
    layer_sequencer_if bus1 ();

    layer_sequencer #(
        .NUM_LAYERS(4), .MIN_WAIT(MIN_WAIT)
`ifdef LAYER_SEQ_WATCHDOG_EN
        , .WDOG_CYCLES(WDOG)
`endif
    ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    layer_sequencer #(
        .NUM_LAYERS(1), .MIN_WAIT(MIN_WAIT)
`ifdef LAYER_SEQ_WATCHDOG_EN
        , .WDOG_CYCLES(WDOG)
`endif
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic       start_m [2];
    logic       valid_m [2];
    logic       load_m  [2];
    logic       cap_m   [2];
    logic       done_m  [2];
    logic       busy_m  [2];
    logic       aff_m   [2];
    logic       bsel_m  [2];
    logic       err_m   [2];
    logic [3:0] lay_m   [2];

    assign bus0.start       = start_m[0];
    assign bus0.layer_valid = valid_m[0];
    assign bus1.start       = start_m[1];
    assign bus1.layer_valid = valid_m[1];

    assign load_m[0] = bus0.layer_load;  assign load_m[1] = bus1.layer_load;
    assign cap_m[0]  = bus0.capture;     assign cap_m[1]  = bus1.capture;
    assign done_m[0] = bus0.done;        assign done_m[1] = bus1.done;
    assign busy_m[0] = bus0.busy;        assign busy_m[1] = bus1.busy;
    assign aff_m[0]  = bus0.is_affine;   assign aff_m[1]  = bus1.is_affine;
    assign bsel_m[0] = bus0.buf_sel;     assign bsel_m[1] = bus1.buf_sel;
    assign err_m[0]  = bus0.err;         assign err_m[1]  = bus1.err;
    assign lay_m[0]  = bus0.cs_layer;    assign lay_m[1]  = bus1.cs_layer;

    int   n_checks = 0;
    int   n_fail   = 0;
    ev_t  load_q   [2][$];
    ev_t  cap_q    [2][$];
    int   capcyc_q [2][$];
    int   done_q   [2][$];
    int   epoch     [2];
    int   fixed_lat [2];
    bit   auto_resp [2];
    int   done_cnt  [2];

    function automatic int nl(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one run visits layers 0..N-1 in order, bank alternates from 0,
    // affine only on the last layer, and the run ends with exactly one done.
    function automatic void push_run(input int d, input int first_cyc);
        for (int k = 0; k < nl(d); k++) begin
            ev_t e;
            e.layer  = k;
            e.bank   = k % 2;
            e.affine = (k == nl(d) - 1) ? 1 : 0;
            e.cyc    = (k == 0) ? first_cyc : -1;
            load_q[d].push_back(e);
            e.cyc = -1;
            cap_q[d].push_back(e);
        end
        done_q[d].push_back(1);
    endfunction

    task automatic monitor(input int d);
        int  last_cap;
        bit  after_done;
        ev_t e;
        int  c;
        last_cap   = -1;
        after_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                after_done = 1'b0;
                continue;
            end
            if (after_done) begin
                check($sformatf("dut%0d busy after done", d), busy_m[d], 0);
                check($sformatf("dut%0d layer held", d), lay_m[d], nl(d) - 1);
                check($sformatf("dut%0d bank held", d), bsel_m[d], (nl(d) - 1) % 2);
                after_done = 1'b0;
            end
            if (load_m[d]) begin
                check($sformatf("dut%0d load expected", d), load_q[d].size() > 0, 1);
                if (load_q[d].size() > 0) begin
                    e = load_q[d].pop_front();
                    check($sformatf("dut%0d load layer", d), lay_m[d], e.layer);
                    check($sformatf("dut%0d load bank", d), bsel_m[d], e.bank);
                    check($sformatf("dut%0d load affine", d), aff_m[d], e.affine);
                    check($sformatf("dut%0d load busy", d), busy_m[d], 1);
                    check($sformatf("dut%0d load err", d), err_m[d], 0);
                    if (e.cyc >= 0) check($sformatf("dut%0d load cycle", d), cyc, e.cyc);
                end
            end
            if (cap_m[d]) begin
                check($sformatf("dut%0d capture expected", d),
                      (cap_q[d].size() > 0) && (capcyc_q[d].size() > 0), 1);
                if ((cap_q[d].size() > 0) && (capcyc_q[d].size() > 0)) begin
                    e = cap_q[d].pop_front();
                    c = capcyc_q[d].pop_front();
                    check($sformatf("dut%0d cap layer", d), lay_m[d], e.layer);
                    check($sformatf("dut%0d cap bank", d), bsel_m[d], e.bank);
                    check($sformatf("dut%0d cap affine", d), aff_m[d], e.affine);
                    check($sformatf("dut%0d cap cycle", d), cyc, c);
                    last_cap = c;
                end
            end
            if (done_m[d]) begin
                done_cnt[d]++;
                check($sformatf("dut%0d done expected", d), done_q[d].size() > 0, 1);
                if (done_q[d].size() > 0) begin
                    void'(done_q[d].pop_front());
                    check($sformatf("dut%0d done cycle", d), cyc, last_cap + 1);
                    after_done = 1'b1;
                end
            end
        end
    endtask

    // Datapath model: valid stays high from the previous result (stale) through the
    // load cycle and the first WAIT cycle, then drops and rises n cycles after load.
    task automatic respond(input int d);
        forever begin
            @(negedge clk);
            if (rst_n && load_m[d] && auto_resp[d]) begin
                int ep;
                int n;
                int l;
                ep = epoch[d];
                l  = cyc;
                n  = (fixed_lat[d] > 0) ? fixed_lat[d] : int'($urandom_range(MAX_LAT, MIN_WAIT));
                repeat (2) @(posedge clk);
                #1;
                if (ep == epoch[d]) begin
                    valid_m[d] = 1'b0;
                    repeat (n - 2) @(posedge clk);
                    #1;
                    if (ep == epoch[d]) begin
                        valid_m[d] = 1'b1;
                        capcyc_q[d].push_back(l + n + 1);
                    end
                end
            end
        end
    endtask

    function automatic logic sig(input int d, input int kind);
        case (kind)
            0:       return load_m[d];
            1:       return done_m[d];
            default: return err_m[d];
        endcase
    endfunction

    task automatic wait_sig(input int d, input int kind, input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!sig(d, kind) && t < 400);
        check(name, sig(d, kind), 1);
    endtask

    task automatic start_run(input int d);
        @(posedge clk);
        #1;
        start_m[d] = 1'b1;
        push_run(d, cyc + 1);
        @(posedge clk);
        #1;
        start_m[d] = 1'b0;
    endtask

    initial monitor(0);
    initial monitor(1);
    initial respond(0);
    initial respond(1);

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        for (int d = 0; d < 2; d++) begin
            start_m[d]   = 1'b0;
            valid_m[d]   = 1'b0;
            epoch[d]     = 0;
            fixed_lat[d] = 0;
            auto_resp[d] = 1'b1;
            done_cnt[d]  = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset busy", d), busy_m[d], 0);
            check($sformatf("dut%0d reset done", d), done_m[d], 0);
            check($sformatf("dut%0d reset load", d), load_m[d], 0);
            check($sformatf("dut%0d reset capture", d), cap_m[d], 0);
            check($sformatf("dut%0d reset layer", d), lay_m[d], 0);
            check($sformatf("dut%0d reset bank", d), bsel_m[d], 0);
            check($sformatf("dut%0d reset err", d), err_m[d], 0);
            check($sformatf("dut%0d reset affine", d), aff_m[d], (d == 1) ? 1 : 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic run, valid 5 cycles after each load.
        fixed_lat[0] = 5;
        start_run(0);
        wait_sig(0, 1, "basic done");

        // Valid left high from FINI, true result 10 cycles after load.
        fixed_lat[0] = 10;
        start_run(0);
        wait_sig(0, 1, "stale done");

        fixed_lat[0] = 0;
        repeat (3) begin
            start_run(0);
            wait_sig(0, 1, "random done");
        end

        // Start pulsed during layer 1 WAIT must be ignored.
        base = done_cnt[0];
        start_run(0);
        wait_sig(0, 0, "busy l0 load");
        wait_sig(0, 0, "busy l1 load");
        @(posedge clk);
        #1;
        start_m[0] = 1'b1;
        @(posedge clk);
        #1;
        start_m[0] = 1'b0;
        wait_sig(0, 1, "busy done");
        repeat (8) @(negedge clk);
        check("busy single done", done_cnt[0] - base, 1);
        check("busy idle after run", busy_m[0], 0);

        // Start held high across FINI -> IDLE restarts one cycle after IDLE.
        start_run(0);
        repeat (4) wait_sig(0, 0, "held load");
        start_m[0] = 1'b1;
        wait_sig(0, 1, "held first done");
        push_run(0, cyc + 2);
        wait_sig(0, 0, "held restart load");
        start_m[0] = 1'b0;
        wait_sig(0, 1, "held second done");

        // Reset during layer 2 WAIT.
        fixed_lat[0] = 0;
        start_run(0);
        repeat (3) wait_sig(0, 0, "rst load");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst busy", busy_m[0], 0);
        check("rst load", load_m[0], 0);
        check("rst capture", cap_m[0], 0);
        check("rst done", done_m[0], 0);
        check("rst layer", lay_m[0], 0);
        check("rst bank", bsel_m[0], 0);
        check("rst affine", aff_m[0], 0);
        epoch[0]++;
        epoch[1]++;
        load_q[0].delete();
        cap_q[0].delete();
        capcyc_q[0].delete();
        done_q[0].delete();
        base = done_cnt[0];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("rst no done", done_cnt[0] - base, 0);
        check("rst idle", busy_m[0], 0);
        fixed_lat[0] = 3;
        start_run(0);
        wait_sig(0, 1, "post-rst done");

        // Single-layer instance.
        repeat (2) begin
            start_run(1);
            wait_sig(1, 1, "one-layer done");
        end

`ifdef LAYER_SEQ_WATCHDOG_EN
        begin
            int s;
            auto_resp[0] = 1'b0;
            @(posedge clk);
            #1;
            valid_m[0] = 1'b0;
            start_m[0] = 1'b1;
            s = cyc;
            begin
                ev_t e;
                e.layer  = 0;
                e.bank   = 0;
                e.affine = 0;
                e.cyc    = s + 1;
                load_q[0].push_back(e);
            end
            @(posedge clk);
            #1;
            start_m[0] = 1'b0;
            wait_sig(0, 2, "wdog err");
            check("wdog err cycle", cyc, s + 2 + WDOG);
            check("wdog busy", busy_m[0], 1);
            repeat (3) @(negedge clk);
            check("wdog err sticky", err_m[0], 1);
            auto_resp[0] = 1'b1;
            fixed_lat[0] = 4;
            start_run(0);
            #1;
            check("wdog err cleared", err_m[0], 0);
            wait_sig(0, 1, "wdog recover done");
        end
`endif

        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d loads drained", d), load_q[d].size(), 0);
            check($sformatf("dut%0d captures drained", d), cap_q[d].size(), 0);
            check($sformatf("dut%0d cap times drained", d), capcyc_q[d].size(), 0);
            check($sformatf("dut%0d dones drained", d), done_q[d].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
